// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: turns one stereo FIFO word per 64-bit frame into
// mclk/bclk/lrclk/sdata, with a one-bit delay between lrclk edges and sample MSBs.
module i2s_tx_serializer #(
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mclk_en,
  input  logic        sclk_en,
  input  logic [63:0] fifo_data,
  input  logic        fifo_valid,
  output logic        fifo_ready,
  output logic        mclk,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        underrun
);

  logic [5:0]              pos;
  logic [5:0]              pos_nxt;
  logic [SAMPLE_WIDTH-1:0] left_q;
  logic [SAMPLE_WIDTH-1:0] right_q;
  logic                    fall_evt;
  logic                    wrap_evt;
  logic                    unused_fifo_bits;

  assign fall_evt = sclk_en & bclk;
  assign wrap_evt = fall_evt & (pos == 6'd63);
  assign pos_nxt  = pos + 6'd1;

  // Bits of fifo_data outside the two sample fields carry no information.
  assign unused_fifo_bits = ^fifo_data;

  // Serial bit for a frame position: left sample MSB at 1, right sample MSB at 33.
  function automatic logic pick_bit(input logic [5:0] p,
                                    input logic [SAMPLE_WIDTH-1:0] l,
                                    input logic [SAMPLE_WIDTH-1:0] r);
    logic b;
    b = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (int'(p) == SAMPLE_WIDTH - i)      b = l[i];
      if (int'(p) == 32 + SAMPLE_WIDTH - i) b = r[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mclk <= 1'b0;
    end else if (mclk_en) begin
      mclk <= ~mclk;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk       <= 1'b0;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      fifo_ready <= 1'b0;
      underrun   <= 1'b0;
      pos        <= 6'd63;
      left_q     <= '0;
      right_q    <= '0;
    end else begin
      fifo_ready <= 1'b0;
      underrun   <= 1'b0;
      if (sclk_en) begin
        bclk <= ~bclk;
      end
      if (fall_evt) begin
        pos   <= pos_nxt;
        lrclk <= pos_nxt[5];
        sdata <= pick_bit(pos_nxt, left_q, right_q);
      end
      // Frame boundary: take the next stereo word, or play silence on an empty FIFO.
      if (wrap_evt) begin
        if (fifo_valid) begin
          left_q     <= fifo_data[32 +: SAMPLE_WIDTH];
          right_q    <= fifo_data[0 +: SAMPLE_WIDTH];
          fifo_ready <= 1'b1;
        end else begin
          left_q     <= '0;
          right_q    <= '0;
          underrun   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: 24-bit and 16-bit instances driven in parallel,
// one table entry per frame plus a mid-frame reset sequence.
`timescale 1ns/1ps
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mclk_en, sclk_en, fifo_valid;
  logic [63:0] fifo_data;
  logic        rd24, mclk24, bclk24, lr24, sd24, ur24;
  logic        rd16, mclk16, bclk16, lr16, sd16, ur16;

  always #5 clk = ~clk;

  i2s_tx_serializer u_dut24 (
    .clk(clk), .reset_n(reset_n), .mclk_en(mclk_en), .sclk_en(sclk_en),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(rd24),
    .mclk(mclk24), .bclk(bclk24), .lrclk(lr24), .sdata(sd24), .underrun(ur24)
  );

  i2s_tx_serializer #(.SAMPLE_WIDTH(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .mclk_en(mclk_en), .sclk_en(sclk_en),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(rd16),
    .mclk(mclk16), .bclk(bclk16), .lrclk(lr16), .sdata(sd16), .underrun(ur16)
  );

  typedef struct {
    logic [63:0] data;
    logic        valid;
    int          sdiv;
    logic [23:0] l24;
    logic [23:0] r24;
    logic [15:0] l16;
    logic [15:0] r16;
  } vec_t;

  vec_t vecs[10];

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   sdiv = 4;
  int   mdiv = 4;
  logic tb_bclk, tb_mclk, fell;
  int   tb_pos;

  task automatic check_int(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clk: drive enables, clock, then advance the reference clock/position model.
  task automatic tick();
    mclk_en = ((cyc % mdiv) == mdiv - 1);
    sclk_en = ((cyc % sdiv) == sdiv - 1);
    @(posedge clk);
    #1;
    cyc++;
    fell = 1'b0;
    if (!reset_n) begin
      tb_bclk = 1'b0;
      tb_mclk = 1'b0;
      tb_pos  = 63;
    end else begin
      if (mclk_en) tb_mclk = ~tb_mclk;
      if (sclk_en) begin
        if (tb_bclk) begin
          fell   = 1'b1;
          tb_pos = (tb_pos + 1) % 64;
        end
        tb_bclk = ~tb_bclk;
      end
    end
  endtask

  // Runs nfalls fall events starting at a wrap; with chk set, compares the frame.
  task automatic run_frame(input int idx, input vec_t v, input int nfalls, input bit chk);
    logic [63:0] sw[2];
    logic [63:0] lw[2];
    int   rd_ticks[2], rd_wrap[2], ur_ticks[2], ur_wrap[2], glitch[2];
    logic cur_sd[2], cur_lr[2], cur_rd[2], cur_ur[2], psd[2], plr[2];
    int   falls, budget, clk_err, brise, bper, mrise, mper;
    logic pb, pm;
    logic [63:0] exp_sd[2];
    sdiv = v.sdiv;
    fifo_data  = v.data;
    fifo_valid = v.valid;
    falls = 0; clk_err = 0; brise = -1; bper = 0; mrise = -1; mper = 0;
    budget = 2 * sdiv * (nfalls + 2) + 16;
    for (int d = 0; d < 2; d++) begin
      sw[d] = '0; lw[d] = '0;
      rd_ticks[d] = 0; rd_wrap[d] = 0; ur_ticks[d] = 0; ur_wrap[d] = 0; glitch[d] = 0;
    end
    psd[0] = sd24; psd[1] = sd16; plr[0] = lr24; plr[1] = lr16;
    pb = bclk24; pm = mclk24;
    while (falls < nfalls && budget > 0) begin
      tick();
      budget--;
      cur_sd[0] = sd24; cur_sd[1] = sd16;
      cur_lr[0] = lr24; cur_lr[1] = lr16;
      cur_rd[0] = rd24; cur_rd[1] = rd16;
      cur_ur[0] = ur24; cur_ur[1] = ur16;
      if (fell) begin
        falls++;
        // Inputs wander between wraps; they must not reach the outputs.
        if (tb_pos == 0) begin
          fifo_data  = ~v.data;
          fifo_valid = ~v.valid;
        end
      end
      for (int d = 0; d < 2; d++) begin
        if (fell) begin
          sw[d][63 - tb_pos] = cur_sd[d];
          lw[d][63 - tb_pos] = cur_lr[d];
        end else if (cur_sd[d] !== psd[d] || cur_lr[d] !== plr[d]) begin
          glitch[d]++;
        end
        if (cur_rd[d] === 1'b1) begin
          rd_ticks[d]++;
          if (fell && tb_pos == 0) rd_wrap[d]++;
        end
        if (cur_ur[d] === 1'b1) begin
          ur_ticks[d]++;
          if (fell && tb_pos == 0) ur_wrap[d]++;
        end
        psd[d] = cur_sd[d];
        plr[d] = cur_lr[d];
      end
      if ({bclk24, bclk16} !== {2{tb_bclk}} || {mclk24, mclk16} !== {2{tb_mclk}}) clk_err++;
      if (bclk24 === 1'b1 && pb === 1'b0) begin
        if (brise >= 0) bper = cyc - brise;
        brise = cyc;
      end
      if (mclk24 === 1'b1 && pm === 1'b0) begin
        if (mrise >= 0) mper = cyc - mrise;
        mrise = cyc;
      end
      pb = bclk24;
      pm = mclk24;
    end
    if (!chk) return;
    exp_sd[0] = {1'b0, v.l24, 7'b0, 1'b0, v.r24, 7'b0};
    exp_sd[1] = {1'b0, v.l16, 15'b0, 1'b0, v.r16, 15'b0};
    check_int($sformatf("v%0d falls_in_budget", idx), falls, nfalls);
    for (int d = 0; d < 2; d++) begin
      check64($sformatf("v%0d d%0d sdata_frame", idx, d), sw[d], exp_sd[d]);
      check64($sformatf("v%0d d%0d lrclk_frame", idx, d), lw[d], 64'h0000_0000_FFFF_FFFF);
      check_int($sformatf("v%0d d%0d fifo_ready_count", idx, d), rd_ticks[d], v.valid ? 1 : 0);
      check_int($sformatf("v%0d d%0d fifo_ready_at_wrap", idx, d), rd_wrap[d], v.valid ? 1 : 0);
      check_int($sformatf("v%0d d%0d underrun_count", idx, d), ur_ticks[d], v.valid ? 0 : 1);
      check_int($sformatf("v%0d d%0d underrun_at_wrap", idx, d), ur_wrap[d], v.valid ? 0 : 1);
      check_int($sformatf("v%0d d%0d change_off_fall", idx, d), glitch[d], 0);
    end
    check_int($sformatf("v%0d clock_toggle_errors", idx), clk_err, 0);
    check_int($sformatf("v%0d bclk_period", idx), bper, 2 * sdiv);
    check_int($sformatf("v%0d mclk_period", idx), mper, 2 * mdiv);
  endtask

  initial begin
    vecs[0] = '{64'h00A5_5A5A_00C3_3C3C, 1'b1, 4,  24'hA55A5A, 24'hC33C3C, 16'h5A5A, 16'h3C3C};
    vecs[1] = '{64'hDEAD_BEEF_CAFE_F00D, 1'b0, 4,  24'h000000, 24'h000000, 16'h0000, 16'h0000};
    vecs[2] = '{64'h0000_8001_0000_7FFE, 1'b1, 4,  24'h008001, 24'h007FFE, 16'h8001, 16'h7FFE};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4,  24'hFFFFFF, 24'hFFFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 1'b1, 4,  24'h345678, 24'hBCDEF0, 16'h5678, 16'hDEF0};
    vecs[5] = '{64'h0080_0001_0000_0001, 1'b1, 4,  24'h800001, 24'h000001, 16'h0001, 16'h0001};
    vecs[6] = '{64'h0000_0000_0000_0000, 1'b0, 4,  24'h000000, 24'h000000, 16'h0000, 16'h0000};
    vecs[7] = '{64'h00A5_5A5A_00C3_3C3C, 1'b1, 16, 24'hA55A5A, 24'hC33C3C, 16'h5A5A, 16'h3C3C};
    vecs[8] = '{64'h5555_AAAA_AAAA_5555, 1'b1, 16, 24'h55AAAA, 24'hAA5555, 16'hAAAA, 16'h5555};
    vecs[9] = '{64'h0000_0001_0080_0000, 1'b1, 4,  24'h000001, 24'h800000, 16'h0001, 16'h0000};

    reset_n = 1'b0; mclk_en = 1'b0; sclk_en = 1'b0;
    fifo_valid = 1'b0; fifo_data = '0;
    tb_bclk = 1'b0; tb_mclk = 1'b0; tb_pos = 63; fell = 1'b0;
    repeat (4) tick();
    check_int("reset_outputs_w24", {mclk24, bclk24, lr24, sd24, rd24, ur24}, 6'b001000);
    check_int("reset_outputs_w16", {mclk16, bclk16, lr16, sd16, rd16, ur16}, 6'b001000);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_frame(i, vecs[i], 64, 1'b1);
    end

    // Reset mid-frame at p=40 while bclk is high and right-channel data is on sdata.
    run_frame(100, vecs[0], 41, 1'b0);
    for (int k = 0; k < 64 && tb_bclk !== 1'b1; k++) tick();
    check_int("pre_reset_pos", tb_pos, 40);
    check_int("pre_reset_sdata_bclk", {sd24, bclk24}, 2'b11);
    reset_n = 1'b0;
    #2;
    check_int("async_reset_w24", {mclk24, bclk24, lr24, sd24, rd24, ur24}, 6'b001000);
    check_int("async_reset_w16", {mclk16, bclk16, lr16, sd16, rd16, ur16}, 6'b001000);
    repeat (6) tick();
    check_int("held_reset_w24", {mclk24, bclk24, lr24, sd24, rd24, ur24}, 6'b001000);
    reset_n = 1'b1;
    run_frame(11, vecs[4], 64, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
